// File: rtl/lsu_stream.sv
// Load/store unit that serialises one memory transaction onto a UART byte
// stream: command flag, address bytes MSB first, then either the store data
// (MSB first) or collection of the load data with a per-byte rx timeout.
module lsu_stream #(
  parameter int         ADDR_BYTES     = 1,
  parameter int         DATA_BYTES     = 2,
  parameter logic [7:0] LOAD_FLAG      = 8'h01,
  parameter logic [7:0] STORE_FLAG     = 8'h02,
  parameter int         TIMEOUT_CYCLES = 65535
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_store,
  input  logic [8*ADDR_BYTES-1:0] req_addr,
  input  logic [8*DATA_BYTES-1:0] req_wdata,
  output logic                    tx_valid,
  output logic [7:0]              tx_byte,
  input  logic                    tx_done,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_data,
  output logic                    rsp_valid,
  output logic                    rsp_err,
  output logic [8*DATA_BYTES-1:0] rsp_rdata
);

  localparam int AW   = 8*ADDR_BYTES;
  localparam int DW   = 8*DATA_BYTES;
  localparam int MAXB = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int CW   = (MAXB > 1) ? $clog2(MAXB) : 1;
  localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_BYTES-1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BYTES-1);
  // Timeout fires on the silent cycle that would bring the count to the limit.
  localparam bit          TO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [15:0] TO_LAST = 16'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES-1 : 0);

  typedef enum logic [2:0] {
    IDLE, SEND_FLAG, SEND_ADDR, SEND_DATA, RECV_DATA, RESP
  } state_t;

  state_t        state;
  logic          store_q;
  logic [AW-1:0] addr_q;     // shifts left as bytes go out; top byte is next
  logic [DW-1:0] wdata_q;    // same scheme for store data
  logic [DW-1:0] rdata_q;    // received bytes shift in at the bottom
  logic [CW-1:0] cnt;
  logic [15:0]   tocnt;

  logic          tx_fire;
  logic [DW-1:0] rdata_nxt;

  // A byte is consumed only while it is actually being offered.
  assign tx_fire   = tx_valid & tx_done;
  assign rdata_nxt = DW'({rdata_q, rx_data});

  // Transaction FSM; all outputs are registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      tx_valid  <= 1'b0;
      tx_byte   <= 8'h00;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      store_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      cnt       <= '0;
      tocnt     <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            store_q   <= req_store;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            rdata_q   <= '0;
            req_ready <= 1'b0;
            tx_valid  <= 1'b1;
            tx_byte   <= req_store ? STORE_FLAG : LOAD_FLAG;
            state     <= SEND_FLAG;
          end
        end
        SEND_FLAG: begin
          if (tx_fire) begin
            cnt     <= '0;
            tx_byte <= addr_q[AW-1 -: 8];
            addr_q  <= addr_q << 8;
            state   <= SEND_ADDR;
          end
        end
        SEND_ADDR: begin
          if (tx_fire) begin
            if (cnt == ADDR_LAST) begin
              cnt <= '0;
              if (store_q) begin
                tx_byte <= wdata_q[DW-1 -: 8];
                wdata_q <= wdata_q << 8;
                state   <= SEND_DATA;
              end else begin
                tx_valid <= 1'b0;
                tocnt    <= '0;
                state    <= RECV_DATA;
              end
            end else begin
              cnt     <= cnt + 1'b1;
              tx_byte <= addr_q[AW-1 -: 8];
              addr_q  <= addr_q << 8;
            end
          end
        end
        SEND_DATA: begin
          if (tx_fire) begin
            if (cnt == DATA_LAST) begin
              tx_valid  <= 1'b0;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_rdata <= '0;
              state     <= RESP;
            end else begin
              cnt     <= cnt + 1'b1;
              tx_byte <= wdata_q[DW-1 -: 8];
              wdata_q <= wdata_q << 8;
            end
          end
        end
        RECV_DATA: begin
          // A byte arriving on the limit cycle takes priority over the timeout.
          if (rx_valid) begin
            tocnt   <= '0;
            rdata_q <= rdata_nxt;
            if (cnt == DATA_LAST) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_rdata <= rdata_nxt;
              state     <= RESP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else if (TO_EN && tocnt == TO_LAST) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= RESP;
          end else begin
            tocnt <= tocnt + 1'b1;
          end
        end
        RESP: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_stream.sv
// Bench for lsu_stream: a default-width unit (8-cycle rx timeout) and a
// 2-address/4-data-byte unit, checked against a byte-stream model.
module tb_lsu_stream;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_assert = 0;
  int n_fail   = 0;

  // default-width unit
  logic        req_valid, req_ready, req_store;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        tx_valid;
  logic [7:0]  tx_byte;
  logic        tx_done = 1'b0;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rsp_valid, rsp_err;
  logic [15:0] rsp_rdata;

  // wide unit
  logic        w_req_valid, w_req_ready, w_req_store;
  logic [15:0] w_req_addr;
  logic [31:0] w_req_wdata;
  logic        w_tx_valid;
  logic [7:0]  w_tx_byte;
  logic        w_tx_done;
  logic        w_rx_valid;
  logic [7:0]  w_rx_data;
  logic        w_rsp_valid, w_rsp_err;
  logic [31:0] w_rsp_rdata;

  lsu_stream #(.TIMEOUT_CYCLES(8)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .tx_valid(tx_valid), .tx_byte(tx_byte), .tx_done(tx_done),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata)
  );

  lsu_stream #(.ADDR_BYTES(2), .DATA_BYTES(4), .TIMEOUT_CYCLES(8)) u_wide (
    .clk(clk), .reset(reset),
    .req_valid(w_req_valid), .req_ready(w_req_ready), .req_store(w_req_store),
    .req_addr(w_req_addr), .req_wdata(w_req_wdata),
    .tx_valid(w_tx_valid), .tx_byte(w_tx_byte), .tx_done(w_tx_done),
    .rx_valid(w_rx_valid), .rx_data(w_rx_data),
    .rsp_valid(w_rsp_valid), .rsp_err(w_rsp_err), .rsp_rdata(w_rsp_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- observation (negedge, away from the active edge)
  logic [7:0]  tx_q[$];
  int          tx_cyc_q[$];
  logic [16:0] rsp_q[$];
  int          rsp_cyc_q[$];
  int          acc_cyc = 0;
  bit          busy = 0;
  bit          pv = 0, pd = 0;
  logic [7:0]  pb = 8'h00;

  always @(negedge clk) begin
    if (reset) begin
      busy = 0;
      pv   = 0;
    end else begin
      chk("req_ready vs busy", req_ready, !busy);
      if (!busy) chk("tx_valid while idle", tx_valid, 0);
      if (tx_valid && pv && !pd) chk("tx_byte stable", tx_byte, pb);
      if (tx_valid && tx_done) begin
        tx_q.push_back(tx_byte);
        tx_cyc_q.push_back(cyc);
      end
      if (rsp_valid) begin
        rsp_q.push_back({rsp_err, rsp_rdata});
        rsp_cyc_q.push_back(cyc);
        busy = 0;
      end
      if (req_valid && req_ready) begin
        busy    = 1;
        acc_cyc = cyc;
      end
      pv = tx_valid;
      pd = tx_done;
      pb = tx_byte;
    end
  end

  logic [7:0]  w_tx_q[$];
  logic [32:0] w_rsp_q[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (w_tx_valid && w_tx_done) w_tx_q.push_back(w_tx_byte);
      if (w_rsp_valid) w_rsp_q.push_back({w_rsp_err, w_rsp_rdata});
    end
  end

  // ---------------- UART tx responder: 0 = tied high, 1 = fixed delay, 2 = random delay
  int done_mode = 0;
  int fixed_dly = 3;
  int age = 0, dly = 1;
  bit rv = 0;

  always begin
    @(posedge clk);
    #1;
    if (!rv || tx_done) begin
      age = 0;
      dly = (done_mode == 2) ? int'($urandom_range(1, 4)) : fixed_dly;
    end else begin
      age++;
    end
    rv = tx_valid;
    tx_done = (done_mode == 0) ? 1'b1 : (tx_valid && age == dly - 1);
  end

  // ---------------- driver helpers
  bit hold_req = 0;
  int rx_last_cyc = 0;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (hold_req) begin
        req_addr  = 8'($urandom);
        req_wdata = 16'($urandom);
        req_store = 1'($urandom);
      end
    end
  endtask

  task automatic issue(input bit st, input logic [7:0] a, input logic [15:0] d);
    int t = 0;
    while (!req_ready && t < 100) begin step(); t++; end
    chk("issue ready", req_ready, 1);
    req_valid = 1; req_store = st; req_addr = a; req_wdata = d;
    step();
    if (!hold_req) req_valid = 0;
  endtask

  // For a load, d holds the bytes the far side returns; nrx < 2 leaves it silent.
  task automatic run_txn(input bit st, input logic [7:0] a, input logic [15:0] d,
                         input int nrx, input int g0, input int g1, input bit stray);
    int t;
    issue(st, a, d);
    if (stray) begin
      t = 0;
      while (tx_q.size() < 1 && t < 100) begin step(); t++; end
      rx_valid = 1; rx_data = 8'hEE;
      step();
      rx_valid = 0;
    end
    if (!st) begin
      t = 0;
      while (tx_q.size() < 2 && t < 100) begin step(); t++; end
      chk("reach rx phase", tx_q.size() >= 2, 1);
      for (int i = 0; i < nrx; i++) begin
        step(i == 0 ? g0 : g1);
        rx_valid = 1;
        rx_data  = (i == 0) ? d[15:8] : d[7:0];
        rx_last_cyc = cyc;
        step();
        rx_valid = 0;
      end
    end
    t = 0;
    while (rsp_q.size() == 0 && t < 200) begin step(); t++; end
    req_valid = 0;
  endtask

  // Reference: expected byte stream and response from the transaction alone.
  task automatic check_txn(input string tag, input bit st, input logic [7:0] a,
                           input logic [15:0] d, input int nrx);
    logic [7:0]  exp_b[$];
    logic [16:0] exp_r;
    bit          err;
    exp_b.push_back(st ? 8'h02 : 8'h01);
    exp_b.push_back(a);
    if (st) begin
      exp_b.push_back(d[15:8]);
      exp_b.push_back(d[7:0]);
    end
    err   = !st && nrx < 2;
    exp_r = st ? 17'h0 : (err ? 17'h10000 : {1'b0, d});
    chk({tag, " tx count"}, tx_q.size(), exp_b.size());
    foreach (exp_b[i]) if (i < tx_q.size()) chk({tag, " tx byte"}, tx_q[i], exp_b[i]);
    chk({tag, " rsp count"}, rsp_q.size(), 1);
    if (rsp_q.size() > 0) chk({tag, " rsp err/rdata"}, rsp_q[0], exp_r);
    tx_q.delete(); tx_cyc_q.delete(); rsp_q.delete(); rsp_cyc_q.delete();
  endtask

  task automatic w_txn(input bit st, input logic [15:0] a, input logic [31:0] d);
    int t = 0;
    logic [7:0]  exp_b[$];
    logic [32:0] exp_r;
    while (!w_req_ready && t < 100) begin step(); t++; end
    w_req_valid = 1; w_req_store = st; w_req_addr = a; w_req_wdata = d;
    step();
    w_req_valid = 0;
    if (!st) begin
      t = 0;
      while (w_tx_q.size() < 3 && t < 100) begin step(); t++; end
      for (int i = 0; i < 4; i++) begin
        w_rx_valid = 1;
        w_rx_data  = d[31-8*i -: 8];
        step();
      end
      w_rx_valid = 0;
    end
    t = 0;
    while (w_rsp_q.size() == 0 && t < 200) begin step(); t++; end
    exp_b.push_back(st ? 8'h02 : 8'h01);
    exp_b.push_back(a[15:8]);
    exp_b.push_back(a[7:0]);
    if (st) for (int i = 0; i < 4; i++) exp_b.push_back(d[31-8*i -: 8]);
    exp_r = st ? 33'h0 : {1'b0, d};
    chk("wide tx count", w_tx_q.size(), exp_b.size());
    foreach (exp_b[i]) if (i < w_tx_q.size()) chk("wide tx byte", w_tx_q[i], exp_b[i]);
    chk("wide rsp count", w_rsp_q.size(), 1);
    if (w_rsp_q.size() > 0) chk("wide rsp err/rdata", w_rsp_q[0], exp_r);
    w_tx_q.delete(); w_rsp_q.delete();
  endtask

  // ---------------- directed + random sequence
  initial begin
    bit          st;
    logic [7:0]  a;
    logic [15:0] d;
    int          rcyc, g0, g1;

    reset = 1;
    req_valid = 0; req_store = 0; req_addr = '0; req_wdata = '0;
    rx_valid = 0; rx_data = '0;
    w_req_valid = 0; w_req_store = 0; w_req_addr = '0; w_req_wdata = '0;
    w_tx_done = 1; w_rx_valid = 0; w_rx_data = '0;
    step(3);

    // reset state
    chk("reset req_ready", req_ready, 1);
    chk("reset tx_valid", tx_valid, 0);
    chk("reset tx_byte", tx_byte, 0);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset rsp_err", rsp_err, 0);
    chk("reset rsp_rdata", rsp_rdata, 0);
    chk("reset wide req_ready", w_req_ready, 1);
    chk("reset wide tx_valid", w_tx_valid, 0);
    reset = 0;
    step(2);

    // store with tx_done tied high: one byte per cycle, response at cycle 5
    done_mode = 0;
    step(3);
    chk("stray tx_done idle bytes", tx_q.size(), 0);
    run_txn(1, 8'h3C, 16'hBEEF, 0, 0, 0, 0);
    for (int i = 0; i < tx_cyc_q.size(); i++) chk("t1 byte cycle", tx_cyc_q[i], acc_cyc + 1 + i);
    chk("t1 rsp cycle", rsp_cyc_q.size() > 0 ? rsp_cyc_q[0] : -1, acc_cyc + 5);
    check_txn("t1 store", 1, 8'h3C, 16'hBEEF, 0);

    // load with each byte held three cycles
    done_mode = 1; fixed_dly = 3;
    step(2);
    run_txn(0, 8'h10, 16'h1234, 2, 2, 1, 0);
    for (int i = 0; i < tx_cyc_q.size(); i++) chk("t2 byte cycle", tx_cyc_q[i], acc_cyc + 3*(i+1));
    chk("t2 rsp after last rx", rsp_cyc_q.size() > 0 ? rsp_cyc_q[0] : -1, rx_last_cyc + 1);
    check_txn("t2 load", 0, 8'h10, 16'h1234, 2);

    // wide unit: 2 address bytes, 4 data bytes
    w_txn(1, 16'hA1B2, 32'h01020304);
    w_txn(0, 16'h7E01, 32'hDEADBEEF);

    // timeout after one byte, then immediate next request
    done_mode = 0;
    step(2);
    run_txn(0, 8'h44, 16'h5500, 1, 0, 0, 0);
    rcyc = rsp_cyc_q.size() > 0 ? rsp_cyc_q[0] : -1;
    chk("t4 timeout cycle", rcyc, rx_last_cyc + 9);
    check_txn("t4 timeout", 0, 8'h44, 16'h5500, 1);
    chk("t4 ready after rsp", req_ready, 1);
    run_txn(1, 8'h99, 16'h0F0F, 0, 0, 0, 0);
    chk("t4 accept next cycle", acc_cyc, rcyc + 1);
    check_txn("t4 next store", 1, 8'h99, 16'h0F0F, 0);

    // byte arriving on the limit cycle wins over the timeout
    run_txn(0, 8'h21, 16'hCAFE, 2, 7, 7, 0);
    check_txn("limit byte wins", 0, 8'h21, 16'hCAFE, 2);

    // stray rx in address phase; request inputs churn after acceptance
    done_mode = 1; fixed_dly = 3;
    step(2);
    hold_req = 1;
    run_txn(1, 8'h6B, 16'h1357, 0, 0, 0, 1);
    hold_req = 0;
    check_txn("t5 store held req", 1, 8'h6B, 16'h1357, 0);
    hold_req = 1;
    run_txn(0, 8'hD4, 16'hA55A, 2, 1, 0, 1);
    hold_req = 0;
    check_txn("t5 load stray rx", 0, 8'hD4, 16'hA55A, 2);

    // reset during the data phase aborts silently
    step(2);
    issue(1, 8'h5A, 16'hC0DE);
    begin
      int t = 0;
      while (tx_q.size() < 2 && t < 100) begin step(); t++; end
    end
    reset = 1;
    step();
    chk("t6 tx_valid after reset", tx_valid, 0);
    chk("t6 req_ready after reset", req_ready, 1);
    chk("t6 rsp_valid after reset", rsp_valid, 0);
    reset = 0;
    step(3);
    chk("t6 no rsp from aborted", rsp_q.size(), 0);
    tx_q.delete(); tx_cyc_q.delete();
    run_txn(0, 8'h0C, 16'h8421, 2, 0, 3, 0);
    check_txn("t6 fresh load", 0, 8'h0C, 16'h8421, 2);

    // random traffic with random tx_done delays and rx gaps inside the limit
    done_mode = 2;
    step(2);
    for (int n = 0; n < 30; n++) begin
      st = 1'($urandom);
      a  = 8'($urandom);
      d  = 16'($urandom);
      g0 = $urandom_range(0, 7);
      g1 = $urandom_range(0, 7);
      run_txn(st, a, d, 2, g0, g1, 0);
      check_txn("random", st, a, d, 2);
    end
    for (int n = 0; n < 4; n++) w_txn(1'($urandom), 16'($urandom), $urandom);

    step(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_stream.md
Name: lsu_stream

Overview:
- Parametrised UART-side load/store unit that serialises one memory transaction into a byte stream.
- Sends a command flag, then the address, then (for a store) the write data, or receives the read data (for a load).
- Sits between the core's memory stage and the UART tx/rx blocks.
- Generalises the fixed 8-bit-address/16-bit-data unit: arbitrary address and data byte counts, a valid/ready request handshake, a registered response, and an rx timeout with an error flag.

Parameters:
- ADDR_BYTES, 1, number of address bytes sent, MSB first (>=1).
- DATA_BYTES, 2, number of data bytes sent or received, MSB first (>=1).
- LOAD_FLAG, 8'h01, command byte sent for a load.
- STORE_FLAG, 8'h02, command byte sent for a store.
- TIMEOUT_CYCLES, 65535, maximum cycles waited for each rx byte; 0 disables the timeout (>=0, fits 16 bits).

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  transaction request.
- req_ready  out  1  unit can accept a request.
- req_store  in  1  1 = store, 0 = load.
- req_addr  in  8*ADDR_BYTES  address.
- req_wdata  in  8*DATA_BYTES  store data.
- tx_valid  out  1  tx_byte is valid; held until tx_done.
- tx_byte  out  8  byte to transmit.
- tx_done  in  1  UART finished the current byte (1-cycle pulse).
- rx_valid  in  1  rx_data holds a received byte (1-cycle pulse).
- rx_data  in  8  received byte.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_err  out  1  qualified by rsp_valid; 1 = load timed out.
- rsp_rdata  out  8*DATA_BYTES  load data, qualified by rsp_valid.

Behaviour:
- Reset values:
  - state IDLE, req_ready=1, tx_valid=0, tx_byte=0.
  - rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - byte counter 0, timeout counter 0.
  - Reset mid-transaction aborts it immediately: no response, tx_valid drops on the next cycle.
- States: IDLE, SEND_FLAG, SEND_ADDR, SEND_DATA, RECV_DATA, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, capture req_store, req_addr and req_wdata into internal registers; go to SEND_FLAG.
  - req_ready=0 in every other state. Input changes after acceptance have no effect.
- SEND_FLAG:
  - tx_valid=1, tx_byte=STORE_FLAG or LOAD_FLAG.
  - On tx_done: go to SEND_ADDR, byte counter=0.
- SEND_ADDR:
  - tx_byte = address byte [ADDR_BYTES-1-cnt], i.e. MSB first.
  - On tx_done: if cnt==ADDR_BYTES-1, go to SEND_DATA (store) or RECV_DATA (load) with cnt=0; else cnt+1.
- SEND_DATA:
  - tx_byte = wdata byte [DATA_BYTES-1-cnt].
  - On tx_done: if last byte, go to RESP with err=0; else cnt+1.
- RECV_DATA:
  - tx_valid=0.
  - On rx_valid: shift rx_data into the rdata register MSB first (first received byte lands in the top byte) and clear the timeout counter.
  - After the last byte: go to RESP with err=0.
  - Without rx_valid: timeout counter+1. When it reaches TIMEOUT_CYCLES (nonzero): go to RESP with err=1 and rdata=0.
  - rx_valid in the same cycle the counter reaches the limit: the byte wins, no timeout.
- RESP:
  - rsp_valid=1 for exactly one cycle with registered rsp_err and rsp_rdata, then IDLE.
  - For a store, rsp_rdata=0.
  - rsp_rdata holds its value until the next response.
- tx_done is sampled only while tx_valid=1. tx_done in the first tx_valid cycle counts. tx_done at any other time is ignored.
- rx_valid is ignored outside RECV_DATA.
- tx_byte changes only on byte advance; it is stable while tx_valid=1.
- Latency with tx_done tied high, accept at edge 0:
  - flag at cycle 1, each following byte one cycle each.
  - Store completion pulse at cycle 2+ADDR_BYTES+DATA_BYTES.
  - Load: rsp_valid the cycle after the last rx_valid.
- A new request can be accepted the cycle after rsp_valid (IDLE).

Test Plan:
1. Defaults; store addr=8'h3C, wdata=16'hBEEF; tx_done tied 1 -> tx_byte sequence 02,3C,BE,EF on cycles 1-4; rsp_valid=1, rsp_err=0 at cycle 5; req_ready=0 throughout cycles 1-5.
2. Defaults; load addr=8'h10; tx_done 3 cycles after each tx_valid rise; rx bytes 12 then 34 -> tx 01,10 each held 3 cycles, stable; rsp_rdata=16'h1234, rsp_err=0, one pulse.
3. ADDR_BYTES=2, DATA_BYTES=4; store addr=16'hA1B2, wdata=32'h01020304 -> tx 02,A1,B2,01,02,03,04 in order; one rsp_valid.
4. TIMEOUT_CYCLES=8; load with one rx byte 55 then silence -> rsp_valid with rsp_err=1, rsp_rdata=0, exactly 8 cycles after the 55 byte; next request accepted the following cycle.
5. Stray tx_done in IDLE and rx_valid during SEND_ADDR; req_valid held with changing req_addr after acceptance -> no state change and no extra bytes; transmitted address equals the value captured at acceptance.
6. Assert reset during SEND_DATA -> next cycle tx_valid=0, req_ready=1, rsp_valid=0; a fresh load then completes normally.
